// File: rtl/snake_body_buffer.sv
// snake_body_buffer
//   Holds the snake's segment coordinates (entry 0 = head) and moves them
//   one grid cell per game tick. Each accepted tick is processed as:
//   SHIFT (move or wall stop), CHECK (one self-collision compare per
//   cycle), then DONE (one-cycle done pulse).
//
// Ports
//   Clock     system clock
//   Reset     synchronous, active-high reset
//   step      one-cycle tick pulse; accepted only while idle and alive
//   dir       requested direction: 0 right, 1 down, 2 up, 3 left
//   grow      sampled with step; keep the tail on this move
//   rd_idx    segment index for the draw FSM
//   rd_x/rd_y coordinates of segment rd_idx; 0 when rd_idx >= length
//   head_x/y  coordinates of segment 0
//   length    current segment count
//   busy      array is being updated or scanned; reads are not stable
//   done      one-cycle pulse when a tick has been fully processed
//   wall_hit  sticky; the head tried to leave the screen
//   self_hit  sticky; the head landed on a body segment
module snake_body_buffer #(
  parameter int         MAXLEN   = 16,
  parameter int         IDXW     = 4,
  parameter int         INIT_LEN = 3,
  parameter int         STEP     = 10,
  parameter logic [7:0] X0       = 8'd40,
  parameter logic [6:0] Y0       = 7'd60,
  parameter int         XSCREEN  = 160,
  parameter int         YSCREEN  = 120
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            step,
  input  logic [1:0]      dir,
  input  logic            grow,
  input  logic [IDXW-1:0] rd_idx,
  output logic [7:0]      rd_x,
  output logic [6:0]      rd_y,
  output logic [7:0]      head_x,
  output logic [6:0]      head_y,
  output logic [IDXW:0]   length,
  output logic            busy,
  output logic            done,
  output logic            wall_hit,
  output logic            self_hit
);

  // Direction encoding puts opposite directions at bitwise complements.
  localparam logic [1:0] DIR_RIGHT = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_UP    = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;

  localparam logic [7:0]      STEP_X   = 8'(STEP);
  localparam logic [6:0]      STEP_Y   = 7'(STEP);
  localparam logic [7:0]      X_LIM    = 8'(XSCREEN - STEP);
  localparam logic [6:0]      Y_LIM    = 7'(YSCREEN - STEP);
  localparam logic [IDXW:0]   LEN_MAX  = (IDXW+1)'(MAXLEN);
  localparam logic [IDXW:0]   LEN_INIT = (IDXW+1)'(INIT_LEN);
  localparam logic [IDXW:0]   LEN_ONE  = (IDXW+1)'(1);
  localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      seg_x_q [MAXLEN];
  logic [6:0]      seg_y_q [MAXLEN];
  logic [IDXW:0]   len_q;
  logic [1:0]      cur_dir_q;
  logic [1:0]      nxt_dir_q;
  logic            grow_q;
  logic [IDXW-1:0] idx_q;
  logic            wall_hit_q;
  logic            self_hit_q;

  logic            dead_s;
  logic            accept_s;
  logic [1:0]      req_dir_s;
  logic            wall_s;
  logic [7:0]      new_x_s;
  logic [6:0]      new_y_s;
  logic            match_s;
  logic            last_idx_s;

  assign dead_s     = wall_hit_q | self_hit_q;
  assign accept_s   = step & ~dead_s;
  assign match_s    = (seg_x_q[idx_q] == seg_x_q[0]) && (seg_y_q[idx_q] == seg_y_q[0]);
  assign last_idx_s = ({1'b0, idx_q} == (len_q - LEN_ONE));

  // Reject a request that would reverse the snake onto itself.
  always_comb begin
    req_dir_s = dir;
    if (dir == ~cur_dir_q) begin
      req_dir_s = cur_dir_q;
    end else begin
      req_dir_s = dir;
    end
  end

  // Next head position and wall test, both from the head before the move.
  always_comb begin
    new_x_s = seg_x_q[0];
    new_y_s = seg_y_q[0];
    wall_s  = 1'b0;
    case (nxt_dir_q)
      DIR_RIGHT: begin
        new_x_s = seg_x_q[0] + STEP_X;
        wall_s  = (seg_x_q[0] >= X_LIM);
      end
      DIR_LEFT: begin
        new_x_s = seg_x_q[0] - STEP_X;
        wall_s  = (seg_x_q[0] < STEP_X);
      end
      DIR_DOWN: begin
        new_y_s = seg_y_q[0] + STEP_Y;
        wall_s  = (seg_y_q[0] >= Y_LIM);
      end
      DIR_UP: begin
        new_y_s = seg_y_q[0] - STEP_Y;
        wall_s  = (seg_y_q[0] < STEP_Y);
      end
      default: begin
        wall_s = 1'b0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) state_d = S_SHIFT;
        else          state_d = S_IDLE;
      end
      S_SHIFT: begin
        if (wall_s) state_d = S_DONE;
        else        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (last_idx_s) state_d = S_DONE;
        else            state_d = S_CHECK;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Segment array, length, direction and collision flags.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < MAXLEN; i++) begin
        if (i < INIT_LEN) begin
          seg_x_q[i] <= X0 - 8'(i * STEP);
          seg_y_q[i] <= Y0;
        end else begin
          seg_x_q[i] <= 8'd0;
          seg_y_q[i] <= 7'd0;
        end
      end
      len_q      <= LEN_INIT;
      cur_dir_q  <= DIR_RIGHT;
      nxt_dir_q  <= DIR_RIGHT;
      grow_q     <= 1'b0;
      idx_q      <= IDX_ONE;
      wall_hit_q <= 1'b0;
      self_hit_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept_s) begin
            nxt_dir_q <= req_dir_s;
            grow_q    <= grow;
          end
        end
        S_SHIFT: begin
          if (wall_s) begin
            wall_hit_q <= 1'b1;
          end else begin
            // Entries past length keep shifting too; they are masked on read.
            for (int i = 1; i < MAXLEN; i++) begin
              seg_x_q[i] <= seg_x_q[i-1];
              seg_y_q[i] <= seg_y_q[i-1];
            end
            seg_x_q[0] <= new_x_s;
            seg_y_q[0] <= new_y_s;
            cur_dir_q  <= nxt_dir_q;
            if (grow_q && (len_q < LEN_MAX)) begin
              len_q <= len_q + LEN_ONE;
            end
            idx_q <= IDX_ONE;
          end
        end
        S_CHECK: begin
          // The scan runs to the end even after a hit for fixed latency.
          if (match_s) begin
            self_hit_q <= 1'b1;
          end
          idx_q <= idx_q + IDX_ONE;
        end
        default: begin
        end
      endcase
    end
  end

  // Indexed read port; anything beyond the live length reads as zero.
  always_comb begin
    rd_x = 8'd0;
    rd_y = 7'd0;
    if ({1'b0, rd_idx} < len_q) begin
      rd_x = seg_x_q[rd_idx];
      rd_y = seg_y_q[rd_idx];
    end else begin
      rd_x = 8'd0;
      rd_y = 7'd0;
    end
  end

  assign head_x   = seg_x_q[0];
  assign head_y   = seg_y_q[0];
  assign length   = len_q;
  assign busy     = (state_q == S_SHIFT) || (state_q == S_CHECK);
  assign done     = (state_q == S_DONE);
  assign wall_hit = wall_hit_q;
  assign self_hit = self_hit_q;

endmodule
